// File: rtl/uart_core_if.sv
// Byte-stream channels of uart_core: TX producer side, RX consumer side and the overrun pulse.
// rx_tuser exists only when UART_RX_ERR_TUSER_EN is defined.
interface uart_core_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_tdata;
  logic                 tx_tvalid;
  logic                 tx_tready;
  logic [DATA_BITS-1:0] rx_tdata;
  logic                 rx_tvalid;
  logic                 rx_tready;
  logic                 rx_overrun;
`ifdef UART_RX_ERR_TUSER_EN
  logic [1:0]           rx_tuser;

  modport master (
    output tx_tdata, tx_tvalid, rx_tready,
    input  tx_tready, rx_tdata, rx_tvalid, rx_overrun, rx_tuser
  );

  modport slave (
    input  tx_tdata, tx_tvalid, rx_tready,
    output tx_tready, rx_tdata, rx_tvalid, rx_overrun, rx_tuser
  );
`else
  modport master (
    output tx_tdata, tx_tvalid, rx_tready,
    input  tx_tready, rx_tdata, rx_tvalid, rx_overrun
  );

  modport slave (
    input  tx_tdata, tx_tvalid, rx_tready,
    output tx_tready, rx_tdata, rx_tvalid, rx_overrun
  );
`endif
endinterface

// File: rtl/uart_core.sv
// uart_core: elaboration-configurable UART (baud, data width, parity, stop bits) with one-byte
// holding registers per direction and RX framing/parity/overrun detection.
// Define UART_RX_ERR_TUSER_EN to deliver errored bytes with rx_tuser = {parity_err, frame_err}.
module uart_core #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic        txd,
  uart_core_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_core: DATA_BITS must be in 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_core: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_core: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_core: CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // Odd mode makes the total count of ones odd, even mode makes it even.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------- TX
  tx_state_t            tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  // TX frame sequencer; txd is updated on the same edge as the state so each bit lasts CLKS_PER_BIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_shift      <= '0;
      tx_par        <= 1'b0;
      txd           <= 1'b1;
      bus.tx_tready <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_tvalid && bus.tx_tready) begin
            tx_shift      <= bus.tx_tdata;
            tx_par        <= parity_of(bus.tx_tdata);
            tx_cnt        <= '0;
            tx_bit        <= '0;
            txd           <= 1'b0;
            bus.tx_tready <= 1'b0;
            tx_state      <= TX_START;
          end else begin
            bus.tx_tready <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == DATA_LAST) begin
              tx_bit <= '0;
              if (PARITY != 0) begin
                txd      <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              txd      <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == STOP_LAST) begin
              tx_bit        <= '0;
              bus.tx_tready <= 1'b1;
              tx_state      <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          txd      <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  logic                 rx_meta;
  logic                 rx_sync;
  rx_state_t            rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_err;
  logic                 rx_stop_hit;
  logic                 rx_frame_err;
  logic                 rx_deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // Mid-stop-bit sample: the single point where a frame is judged complete or errored.
  assign rx_stop_hit  = (rx_state == RX_STOP) && (rx_cnt == CNT_LAST);
  assign rx_frame_err = rx_stop_hit && !rx_sync;
`ifdef UART_RX_ERR_TUSER_EN
  assign rx_deliver   = rx_stop_hit;
`else
  assign rx_deliver   = rx_stop_hit && rx_sync && !rx_par_err;
`endif

  // RX frame sequencer; START waits half a bit so later samples land mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_err <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) begin
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt <= '0;
            if (!rx_sync) begin
              rx_bit     <= '0;
              rx_par_err <= 1'b0;
              rx_state   <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == DATA_LAST) begin
              rx_bit   <= '0;
              rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt     <= '0;
            rx_par_err <= (rx_sync != parity_of(rx_shift));
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          rx_cnt <= '0;
          if (rx_sync) begin
            rx_state <= RX_IDLE;
          end
        end
        default: begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Holding register: a byte arriving on the handshake cycle replaces the old one without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_tdata   <= '0;
      bus.rx_tvalid  <= 1'b0;
      bus.rx_overrun <= 1'b0;
`ifdef UART_RX_ERR_TUSER_EN
      bus.rx_tuser   <= 2'b00;
`endif
    end else begin
      bus.rx_overrun <= 1'b0;
      if (bus.rx_tvalid && bus.rx_tready) begin
        bus.rx_tvalid <= 1'b0;
      end
      if (rx_deliver) begin
        if (!bus.rx_tvalid || bus.rx_tready) begin
          bus.rx_tdata  <= rx_shift;
          bus.rx_tvalid <= 1'b1;
`ifdef UART_RX_ERR_TUSER_EN
          bus.rx_tuser  <= {rx_par_err, rx_frame_err};
`endif
        end else begin
          bus.rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: 10 clocks per bit, 8 data bits, odd parity, 2 stop bits.
// Expected line waveforms and RX results come from a frame model built from the UART framing rules.
module tb_uart_core;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DB     = 8;
  localparam int unsigned PAR    = 1;
  localparam int unsigned SB     = 2;
  localparam int unsigned C      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned FB     = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
`ifdef UART_RX_ERR_TUSER_EN
  localparam bit TUSER_EN = 1'b1;
`else
  localparam bit TUSER_EN = 1'b0;
`endif

  typedef logic [FB-1:0] frame_t;
  typedef struct {
    logic [DB-1:0] data;
    logic [1:0]    user;
  } rx_item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rxd;
  logic txd;
  logic [1:0] rx_user;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt = 0;
  longint cyc = 0;
  rx_item_t got_q[$];

  uart_core_if #(.DATA_BITS(DB)) bus ();

  uart_core #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DATA_BITS  (DB),
    .PARITY     (PAR),
    .STOP_BITS  (SB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rxd  (rxd),
    .txd  (txd),
    .bus  (bus)
  );

  assign rxd = loop_en ? txd : rxd_drv;
`ifdef UART_RX_ERR_TUSER_EN
  assign rx_user = bus.rx_tuser;
`else
  assign rx_user = 2'b00;
`endif

  always #5 clk = ~clk;

  // Records every accepted RX byte and every overrun cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.rx_tvalid === 1'b1 && bus.rx_tready === 1'b1)
        got_q.push_back('{data: bus.rx_tdata, user: rx_user});
      if (bus.rx_overrun === 1'b1)
        ovr_cnt++;
    end
  end

  // ------------------------------------------------------------ model
  function automatic logic par_bit(input logic [DB-1:0] d);
    int ones;
    ones = $countones(d);
    if (PAR == 1) return ((ones % 2) == 0);
    return ((ones % 2) == 1);
  endfunction

  function automatic frame_t make_frame(input logic [DB-1:0] d, input bit bad_par, input bit stop_val);
    frame_t f;
    int p;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1 + i] = d[i];
    p = 1 + DB;
    if (PAR != 0) begin
      f[p] = par_bit(d) ^ bad_par;
      p++;
    end
    f[p] = stop_val;
    return f;
  endfunction

  // ------------------------------------------------------------ helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tready(input string tag);
    int n;
    n = 0;
    while (bus.tx_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check({tag, "_tready_timeout"}, 32'(bus.tx_tready), 32'd1);
  endtask

  // Sends one byte and compares every txd cycle against the modelled frame.
  task automatic tx_frame(input logic [DB-1:0] d, input string tag);
    frame_t f;
    int bad;
    f = make_frame(d, 1'b0, 1'b1);
    wait_tready(tag);
    bus.tx_tdata  = d;
    bus.tx_tvalid = 1'b1;
    @(negedge clk);
    bus.tx_tvalid = 1'b0;
    bad = -1;
    for (int k = 0; k < int'(C * FB); k++) begin
      if (k > 0) @(negedge clk);
      if (bad < 0 && (txd !== f[k / C] || bus.tx_tready !== 1'b0)) bad = k;
    end
    check({tag, "_wave_first_bad_cycle"}, 32'(bad), 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_tready_after_frame"}, 32'(bus.tx_tready), 32'd1);
    check({tag, "_txd_idle"}, 32'(txd), 32'd1);
  endtask

  task automatic drive_rx(input logic [DB-1:0] d, input bit bad_par, input bit stop_val);
    frame_t f;
    f = make_frame(d, bad_par, stop_val);
    for (int i = 0; i < int'(FB); i++) begin
      rxd_drv = f[i];
      repeat (C) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic expect_rx(input string tag, input logic [DB-1:0] d, input logic [1:0] user, input bit deliver);
    repeat (C) @(negedge clk);
    if (deliver) begin
      check({tag, "_count"}, 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) begin
        check({tag, "_data"}, 32'(got_q[0].data), 32'(d));
        check({tag, "_user"}, 32'(got_q[0].user), 32'(user));
      end
    end else begin
      check({tag, "_count"}, 32'(got_q.size()), 32'd0);
    end
    got_q.delete();
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    logic [DB-1:0] s[5];
    logic [DB-1:0] d;
    bit bp;
    longint hs, hs_prev;
    int n, ovr0;
    logic perr0;

    bus.tx_tdata  = '0;
    bus.tx_tvalid = 1'b0;
    bus.rx_tready = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tready", 32'(bus.tx_tready), 32'd0);
    check("rst_rx_tvalid", 32'(bus.rx_tvalid), 32'd0);
    check("rst_rx_tdata", 32'(bus.rx_tdata), 32'd0);
    check("rst_rx_overrun", 32'(bus.rx_overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_tready_first_cycle", 32'(bus.tx_tready), 32'd1);

    // TX waveform: fixed pattern then random bytes
    tx_frame(8'hA5, "t1_a5");
    for (int i = 0; i < 3; i++) tx_frame(DB'($urandom), "t1_rand");

    // loopback stream with tvalid held
    loop_en = 1'b1;
    bus.rx_tready = 1'b1;
    got_q.delete();
    s[0] = 8'h00; s[1] = 8'hFF; s[2] = 8'h3C; s[3] = DB'($urandom); s[4] = DB'($urandom);
    hs_prev = 0;
    bus.tx_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.tx_tdata = s[i];
      n = 0;
      while (bus.tx_tready !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("t2_tready_seen", 32'(bus.tx_tready), 32'd1);
      hs = cyc;
      if (i > 0) check("t2_frame_gap", 32'(hs - hs_prev), 32'(C * FB + 1));
      hs_prev = hs;
      @(negedge clk);
    end
    bus.tx_tvalid = 1'b0;
    repeat (C * FB + 3 * C) @(negedge clk);
    check("t2_rx_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check("t2_rx_data", 32'(got_q[i].data), 32'(s[i]));
    end
    got_q.delete();
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    repeat (2 * C) @(negedge clk);

    // RX parity error, then random good/bad frames
    drive_rx(8'h55, 1'b1, 1'b1);
    expect_rx("t3_bad_parity", 8'h55, 2'b10, TUSER_EN);
    for (int i = 0; i < 6; i++) begin
      d  = DB'($urandom);
      bp = ($urandom_range(0, 2) == 0);
      drive_rx(d, bp, 1'b1);
      expect_rx(bp ? "t3_rand_bad" : "t3_rand_good", d, {bp, 1'b0}, !bp || TUSER_EN);
    end

    // break: 30 bit times low, then a normal byte
    perr0 = (PAR != 0) ? (par_bit('0) != 1'b0) : 1'b0;
    rxd_drv = 1'b0;
    repeat (30 * C) @(negedge clk);
    check("t4_break_count", 32'(got_q.size()), 32'(TUSER_EN));
    if (got_q.size() > 0) check("t4_break_user", 32'(got_q[0].user), 32'({perr0, 1'b1}));
    check("t4_break_tvalid", 32'(bus.rx_tvalid), 32'd0);
    got_q.delete();
    rxd_drv = 1'b1;
    repeat (C) @(negedge clk);
    drive_rx(8'h41, 1'b0, 1'b1);
    expect_rx("t4_after_break", 8'h41, 2'b00, 1'b1);

    // overrun
    bus.rx_tready = 1'b0;
    ovr0 = ovr_cnt;
    drive_rx(8'h11, 1'b0, 1'b1);
    repeat (C) @(negedge clk);
    check("t5_first_tvalid", 32'(bus.rx_tvalid), 32'd1);
    check("t5_first_data", 32'(bus.rx_tdata), 32'h11);
    drive_rx(8'h22, 1'b0, 1'b1);
    repeat (C) @(negedge clk);
    check("t5_kept_data", 32'(bus.rx_tdata), 32'h11);
    check("t5_kept_tvalid", 32'(bus.rx_tvalid), 32'd1);
    check("t5_overrun_cycles", 32'(ovr_cnt - ovr0), 32'd1);
    bus.rx_tready = 1'b1;
    @(negedge clk);
    check("t5_tvalid_cleared", 32'(bus.rx_tvalid), 32'd0);
    check("t5_accept_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("t5_accept_data", 32'(got_q[0].data), 32'h11);
    got_q.delete();

    // glitch rejection with a byte pending, then reset mid TX frame
    bus.rx_tready = 1'b0;
    drive_rx(8'h5A, 1'b0, 1'b1);
    repeat (C) @(negedge clk);
    check("t6_pending_tvalid", 32'(bus.rx_tvalid), 32'd1);
    ovr0 = ovr_cnt;
    rxd_drv = 1'b0;
    repeat (2) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (FB * C) @(negedge clk);
    check("t6_glitch_overrun", 32'(ovr_cnt - ovr0), 32'd0);
    check("t6_glitch_data", 32'(bus.rx_tdata), 32'h5A);
    wait_tready("t6");
    bus.tx_tdata  = 8'h00;
    bus.tx_tvalid = 1'b1;
    @(negedge clk);
    bus.tx_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_txd_start_bit", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_async_txd", 32'(txd), 32'd1);
    check("t6_async_rx_tvalid", 32'(bus.rx_tvalid), 32'd0);
    check("t6_async_tready", 32'(bus.tx_tready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_tready_after_reset", 32'(bus.tx_tready), 32'd1);
    check("t6_txd_after_reset", 32'(txd), 32'd1);
    check("t6_rx_tvalid_after_reset", 32'(bus.rx_tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
